bram_dp_pipe: RTL and testbench
===============================

// Module: bram_dp_pipe
// PURPOSE
//   Parametrised true dual-port block RAM with byte-lane write enables, selectable read latency
//   (1 or 2 cycles), per-port read-valid strobes and per-port read-during-write mode.
//   Successor to the single-port 16 kB user-project BRAM. Serves as shared memory between the
//   Wishbone-side firmware path (port 0) and a user accelerator (port 1).
//   The array is inferred as block RAM. Only the output/valid pipeline and the collision flag are reset.
// PARAMETERS
//   DATA_WIDTH    32            word width in bits; must be a multiple of 8
//   ADDR_WIDTH    12            word-address width; depth = 2**ADDR_WIDTH words (default 16 kB)
//   READ_LATENCY  1             1 = array output registered once; 2 = extra output register stage
//   WRITE_MODE0   "READ_FIRST"  port 0 same-port read-during-write: "READ_FIRST" | "WRITE_FIRST"
//   WRITE_MODE1   "READ_FIRST"  port 1, same encoding
// PORTS
//   CLK    in   1             single clock, all logic rising-edge
//   RST_N  in   1             asynchronous active-low reset
//   EN0    in   1             port 0 access enable
//   WE0    in   DATA_WIDTH/8  port 0 byte-lane write enables (bit i -> Di0[8i+7:8i])
//   A0     in   ADDR_WIDTH    port 0 word address
//   Di0    in   DATA_WIDTH    port 0 write data
//   Do0    out  DATA_WIDTH    port 0 read data
//   VLD0   out  1             port 0 Do0 valid strobe
//   EN1, WE1, A1, Di1, Do1, VLD1    port 1, identical to port 0
//   COLL   out  1             sticky: both ports wrote the same address in one cycle
// BEHAVIOUR
// - Reset (RST_N=0, async): Do0/Do1=0, VLD0/VLD1=0, COLL=0, all pipeline stages cleared.
//   Array contents retained. No array write while RST_N=0. Reads in flight at reset are discarded.
// - Access: EN=1 at edge k is a read; it is also a write for lanes with WE bit set.
//   Do/VLD appear after edge k+READ_LATENCY-1 (latency 1: visible in the cycle following edge k).
// - Idle: EN=0 at edge k gives VLD=0 and Do=0 at the matching output cycle (zero-when-idle).
//   With READ_LATENCY=2, idle zeroing propagates through both stages.
// - Pipelining: back-to-back EN=1 every cycle yields one VLD per cycle, in order, with no bubbles.
//   No stall input.
// - Same-port read-during-write:
//   - READ_FIRST: Do returns the pre-write word.
//   - WRITE_FIRST: Do returns the merged word (written lanes = Di, other lanes = old).
//   - WE=0 is a pure read in both modes.
// - Cross-port, same address, one writes while the other reads: the reader gets the pre-write word.
//   The write is visible to the reader from the next access.
// - Cross-port, both write the same address:
//   - Lanes enabled on both ports take port 0 data; lanes enabled on one port take that port's data.
//   - COLL sets at that edge and stays 1 until reset. Distinct addresses never set COLL.
// - Address is word-granular. No wrap logic is needed because A is exactly ADDR_WIDTH bits.
// - Elaboration: DATA_WIDTH%8!=0, READ_LATENCY not in {1,2}, or an invalid WRITE_MODE -> $error.
// TESTING
// 1 Reset/idle:
//   RST_N low 3 cycles, EN0=EN1=0 -> Do0=Do1=0, VLD=0, COLL=0; deassert, idle 5 cycles -> unchanged.
// 2 Byte lanes, latency 1:
//   P0 write A=0x005 Di=0xAABBCCDD WE=0xF; then write WE=0x2 Di=0x00001100; then read
//   -> Do0=0xAABB11DD with VLD0=1 one cycle after the read edge.
// 3 Streaming, READ_LATENCY=2:
//   P1 reads A=0..7 on consecutive cycles -> VLD1 high 8 cycles, starting 2 cycles after first EN,
//   data in address order.
// 4 Read-during-write:
//   - Word 0x010=0x11111111; P0 write 0x22222222 WE=0xF with EN0=1 -> READ_FIRST Do0=0x11111111,
//     WRITE_FIRST Do0=0x22222222.
//   - P1 reading 0x010 in the same cycle -> Do1=0x11111111.
// 5 Collision:
//   P0 WE=0x3 Di=0xAAAAAAAA, P1 WE=0x6 Di=0x55555555, both A=0x020, old word 0
//   -> read back 0x0055AAAA; COLL=1 and stays 1 until RST_N pulse.
// 6 Reset mid-operation:
//   Assert RST_N low between read edge and output -> Do=0, VLD=0 immediately.
//   Data written before reset reads back intact after release.

Source files
------------

// File: rtl/bram_dp_pipe.sv
// True dual-port block RAM with byte lanes, 1- or 2-cycle read latency,
// per-port read-during-write mode and a sticky same-address write collision flag.
module bram_dp_pipe #(
    parameter int    DATA_WIDTH   = 32,
    parameter int    ADDR_WIDTH   = 12,
    parameter int    READ_LATENCY = 1,
    parameter string WRITE_MODE0  = "READ_FIRST",
    parameter string WRITE_MODE1  = "READ_FIRST"
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    EN0,
    input  logic [DATA_WIDTH/8-1:0] WE0,
    input  logic [ADDR_WIDTH-1:0]   A0,
    input  logic [DATA_WIDTH-1:0]   Di0,
    output logic [DATA_WIDTH-1:0]   Do0,
    output logic                    VLD0,
    input  logic                    EN1,
    input  logic [DATA_WIDTH/8-1:0] WE1,
    input  logic [ADDR_WIDTH-1:0]   A1,
    input  logic [DATA_WIDTH-1:0]   Di1,
    output logic [DATA_WIDTH-1:0]   Do1,
    output logic                    VLD1,
    output logic                    COLL
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam bit WF0   = (WRITE_MODE0 == "WRITE_FIRST");
    localparam bit WF1   = (WRITE_MODE1 == "WRITE_FIRST");

    if (DATA_WIDTH % 8 != 0) begin : g_bad_width
        $error("bram_dp_pipe: DATA_WIDTH must be a multiple of 8");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_lat
        $error("bram_dp_pipe: READ_LATENCY must be 1 or 2");
    end
    if (WRITE_MODE0 != "READ_FIRST" && WRITE_MODE0 != "WRITE_FIRST") begin : g_bad_wm0
        $error("bram_dp_pipe: invalid WRITE_MODE0");
    end
    if (WRITE_MODE1 != "READ_FIRST" && WRITE_MODE1 != "WRITE_FIRST") begin : g_bad_wm1
        $error("bram_dp_pipe: invalid WRITE_MODE1");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [DATA_WIDTH-1:0] old0, old1, mrg0, mrg1, rd0, rd1;
    logic [DATA_WIDTH-1:0] s1_d0, s1_d1;
    logic                  s1_v0, s1_v1;
    logic                  coll_now, coll_q;

    // Array write: port 1 lanes first so port 0 wins lanes both ports enable.
    always_ff @(posedge CLK) begin
        if (RST_N) begin
            for (int i = 0; i < NB; i++) begin
                if (EN1 && WE1[i]) mem[A1][8*i +: 8] <= Di1[8*i +: 8];
                if (EN0 && WE0[i]) mem[A0][8*i +: 8] <= Di0[8*i +: 8];
            end
        end
    end

    // Read word per port: old word, or own-port merged word in write-first mode.
    always_comb begin
        old0 = mem[A0];
        old1 = mem[A1];
        mrg0 = old0;
        mrg1 = old1;
        for (int i = 0; i < NB; i++) begin
            if (WE0[i]) mrg0[8*i +: 8] = Di0[8*i +: 8];
            if (WE1[i]) mrg1[8*i +: 8] = Di1[8*i +: 8];
        end
        rd0 = WF0 ? mrg0 : old0;
        rd1 = WF1 ? mrg1 : old1;
        coll_now = EN0 && EN1 && (|WE0) && (|WE1) && (A0 == A1);
    end

    // First output stage and sticky collision flag; idle cycles load zero.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1_d0  <= '0;
            s1_d1  <= '0;
            s1_v0  <= 1'b0;
            s1_v1  <= 1'b0;
            coll_q <= 1'b0;
        end else begin
            s1_v0  <= EN0;
            s1_v1  <= EN1;
            s1_d0  <= EN0 ? rd0 : '0;
            s1_d1  <= EN1 ? rd1 : '0;
            coll_q <= coll_q | coll_now;
        end
    end

    assign COLL = coll_q;

    if (READ_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] s2_d0, s2_d1;
        logic                  s2_v0, s2_v1;

        // Extra output register stage; carries zeros through idle cycles.
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                s2_d0 <= '0;
                s2_d1 <= '0;
                s2_v0 <= 1'b0;
                s2_v1 <= 1'b0;
            end else begin
                s2_d0 <= s1_d0;
                s2_d1 <= s1_d1;
                s2_v0 <= s1_v0;
                s2_v1 <= s1_v1;
            end
        end

        assign Do0  = s2_d0;
        assign Do1  = s2_d1;
        assign VLD0 = s2_v0;
        assign VLD1 = s2_v1;
    end else begin : g_lat1
        assign Do0  = s1_d0;
        assign Do1  = s1_d1;
        assign VLD0 = s1_v0;
        assign VLD1 = s1_v1;
    end

endmodule

// File: tb/tb_bram_dp_pipe.sv
// Directed bench for bram_dp_pipe: instance a is latency 1 / read-first,
// instance b is latency 2 with write-first on port 0; both share stimulus.
module tb_bram_dp_pipe;

    logic        CLK;
    logic        RST_N;
    logic        EN0, EN1;
    logic [3:0]  WE0, WE1;
    logic [11:0] A0, A1;
    logic [31:0] Di0, Di1;

    logic [31:0] a_do0, a_do1, b_do0, b_do1;
    logic        a_vld0, a_vld1, b_vld0, b_vld1;
    logic        a_coll, b_coll;

    int vec_cnt = 0;
    int err_cnt = 0;

    bram_dp_pipe #(
        .READ_LATENCY(1)
    ) u_a (
        .CLK(CLK), .RST_N(RST_N),
        .EN0(EN0), .WE0(WE0), .A0(A0), .Di0(Di0), .Do0(a_do0), .VLD0(a_vld0),
        .EN1(EN1), .WE1(WE1), .A1(A1), .Di1(Di1), .Do1(a_do1), .VLD1(a_vld1),
        .COLL(a_coll)
    );

    bram_dp_pipe #(
        .READ_LATENCY(2),
        .WRITE_MODE0("WRITE_FIRST")
    ) u_b (
        .CLK(CLK), .RST_N(RST_N),
        .EN0(EN0), .WE0(WE0), .A0(A0), .Di0(Di0), .Do0(b_do0), .VLD0(b_vld0),
        .EN1(EN1), .WE1(WE1), .A1(A1), .Di1(Di1), .Do1(b_do1), .VLD1(b_vld1),
        .COLL(b_coll)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        EN0 = 0; WE0 = 0; EN1 = 0; WE1 = 0;
    endtask

    task automatic p0(input logic [11:0] a, input logic [3:0] we,
                      input logic [31:0] d);
        EN0 = 1; A0 = a; WE0 = we; Di0 = d;
    endtask

    task automatic p1(input logic [11:0] a, input logic [3:0] we,
                      input logic [31:0] d);
        EN1 = 1; A1 = a; WE1 = we; Di1 = d;
    endtask

    initial begin
        RST_N = 0;
        A0 = 0; A1 = 0; Di0 = 0; Di1 = 0;
        idle();

        // 1 reset / idle
        repeat (3) step();
        chk("rst_do0", a_do0, 0);
        chk("rst_do1", b_do1, 0);
        chk("rst_vld", {28'd0, a_vld0, a_vld1, b_vld0, b_vld1}, 0);
        chk("rst_coll", {30'd0, a_coll, b_coll}, 0);
        RST_N = 1;
        repeat (5) step();
        chk("idle_do", a_do0 | a_do1 | b_do0 | b_do1, 0);
        chk("idle_vld", {28'd0, a_vld0, a_vld1, b_vld0, b_vld1}, 0);
        chk("idle_coll", {30'd0, a_coll, b_coll}, 0);

        // 2 byte lanes
        p0(12'h005, 4'hF, 32'hAABBCCDD);
        step();
        p0(12'h005, 4'h2, 32'h00001100);
        step();
        chk("lane_rf_old", a_do0, 32'hAABBCCDD);
        chk("lane_wf_lat2", b_do0, 32'hAABBCCDD);
        p0(12'h005, 4'h0, 32'h0);
        step();
        chk("lane_rd", a_do0, 32'hAABB11DD);
        chk("lane_vld", {31'd0, a_vld0}, 1);
        chk("lane_wf_mrg", b_do0, 32'hAABB11DD);
        idle();
        step();
        chk("lane_lat2", b_do0, 32'hAABB11DD);
        chk("lane_lat2_vld", {31'd0, b_vld0}, 1);
        chk("idle_zero_do", a_do0, 0);
        chk("idle_zero_vld", {31'd0, a_vld0}, 0);
        step();
        chk("idle_zero_lat2", {b_do0[30:0], b_vld0}, 0);

        // 3 streaming on port 1
        for (int i = 0; i < 8; i++) begin
            p0(12'(i), 4'hF, 32'h10000000 + i);
            step();
        end
        idle();
        for (int c = 0; c < 10; c++) begin
            if (c < 8) p1(12'(c), 4'h0, 32'h0);
            else idle();
            step();
            chk($sformatf("strm_vld%0d", c), {31'd0, b_vld1},
                (c >= 1 && c <= 8) ? 32'd1 : 32'd0);
            chk($sformatf("strm_d%0d", c), b_do1,
                (c >= 1 && c <= 8) ? 32'h10000000 + c - 1 : 32'd0);
        end

        // 4 read-during-write
        p0(12'h010, 4'hF, 32'h11111111);
        step();
        p0(12'h010, 4'hF, 32'h22222222);
        p1(12'h010, 4'h0, 32'h0);
        step();
        chk("rdw_rf", a_do0, 32'h11111111);
        chk("rdw_x1", a_do1, 32'h11111111);
        idle();
        step();
        chk("rdw_wf", b_do0, 32'h22222222);
        chk("rdw_x1_lat2", b_do1, 32'h11111111);
        p1(12'h010, 4'h0, 32'h0);
        step();
        chk("rdw_next", a_do1, 32'h22222222);
        idle();

        // 5 collision
        p0(12'h020, 4'hF, 32'h0);
        step();
        chk("coll_pre", {30'd0, a_coll, b_coll}, 0);
        p0(12'h020, 4'h3, 32'hAAAAAAAA);
        p1(12'h020, 4'h6, 32'h55555555);
        step();
        chk("coll_set", {30'd0, a_coll, b_coll}, 3);
        idle();
        p0(12'h020, 4'h0, 32'h0);
        step();
        chk("coll_data", a_do0, 32'h0055AAAA);
        idle();
        repeat (4) step();
        chk("coll_sticky", {30'd0, a_coll, b_coll}, 3);

        // 6 reset mid-operation
        p0(12'h020, 4'h0, 32'h0);
        step();
        RST_N = 0;
        #1;
        chk("mid_do", a_do0 | b_do0, 0);
        chk("mid_vld", {30'd0, a_vld0, b_vld0}, 0);
        chk("mid_coll", {30'd0, a_coll, b_coll}, 0);
        p0(12'h020, 4'hF, 32'hFFFFFFFF);
        step();
        idle();
        step();
        RST_N = 1;
        step();
        chk("mid_flush", {30'd0, a_vld0, b_vld0}, 0);
        p0(12'h020, 4'h0, 32'h0);
        p1(12'h005, 4'h0, 32'h0);
        step();
        chk("keep_020", a_do0, 32'h0055AAAA);
        chk("keep_005", a_do1, 32'h10000005);
        p0(12'h030, 4'hF, 32'h1);
        p1(12'h031, 4'hF, 32'h2);
        step();
        chk("no_coll", {30'd0, a_coll, b_coll}, 0);
        idle();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
